// File: rtl/midi_tx_encoder_if.sv
// Handshake and line signals between a MIDI message source and midi_tx_encoder.
interface midi_tx_encoder_if;
    logic       msg_valid;
    logic       msg_ready;
    logic [2:0] msg_type;
    logic [3:0] msg_ch;
    logic [6:0] msg_d1;
    logic [6:0] msg_d2;
    logic       rt_valid;
    logic       rt_ready;
    logic [7:0] rt_data;
    logic       midi_txd;
    logic       tx_busy;
    logic       byte_sent;

    modport master (
        output msg_valid, msg_type, msg_ch, msg_d1, msg_d2, rt_valid, rt_data,
        input  msg_ready, rt_ready, midi_txd, tx_busy, byte_sent
    );

    modport slave (
        input  msg_valid, msg_type, msg_ch, msg_d1, msg_d2, rt_valid, rt_data,
        output msg_ready, rt_ready, midi_txd, tx_busy, byte_sent
    );
endinterface

// File: rtl/midi_tx_encoder.sv
// MIDI transmit path: channel-voice encoder with running status, realtime byte
// insertion between message bytes, and an 8N1 serialiser at CLK_DIV clocks per bit.
module midi_tx_encoder #(
    parameter int CLK_DIV    = 800,
    parameter int RUN_STATUS = 1
) (
    input  logic             CLOCK_25,
    input  logic             reset,
    midi_tx_encoder_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [2:0] E_IDLE   = 3'd0;
    localparam logic [2:0] E_STATUS = 3'd1;
    localparam logic [2:0] E_D1     = 3'd2;
    localparam logic [2:0] E_D2     = 3'd3;
    localparam logic [2:0] E_DROP   = 3'd4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [2:0]       e_state;
    logic [2:0]       m_type;
    logic [3:0]       m_ch;
    logic [6:0]       m_d1;
    logic [6:0]       m_d2;
    logic [7:0]       last_status;
    logic             rt_pending;
    logic [7:0]       rt_byte;
    logic [1:0]       s_state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             txd_p0;
    logic             sent_p0;

    logic [7:0] status_byte;
    logic [7:0] enc_byte;
    logic [7:0] load_byte;
    logic       bit_end;
    logic       ser_free;
    logic       enc_has;
    logic       rt_load;
    logic       enc_load;
    logic       load;
    logic       msg_acc;
    logic       rt_acc;
    logic       line;

    assign status_byte = {1'b1, m_type, m_ch};
    assign bit_end     = (div_cnt == DIV_LAST);
    // The last stop-bit cycle counts as free so a queued byte follows with no gap.
    assign ser_free    = (s_state == S_IDLE) || (s_state == S_STOP && bit_end);
    assign enc_has     = (e_state == E_STATUS) || (e_state == E_D1) || (e_state == E_D2);
    assign rt_load     = ser_free && rt_pending;
    assign enc_load    = ser_free && !rt_pending && enc_has;
    assign load        = rt_load || enc_load;
    assign load_byte   = rt_pending ? rt_byte : enc_byte;
    assign msg_acc     = bus.msg_valid && bus.msg_ready;
    assign rt_acc      = bus.rt_valid && bus.rt_ready;

    always_comb begin
        enc_byte = {1'b0, m_d1};
        case (e_state)
            E_STATUS: enc_byte = status_byte;
            E_D2:     enc_byte = {1'b0, m_d2};
            default:  enc_byte = {1'b0, m_d1};
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            e_state     <= E_IDLE;
            last_status <= 8'h00;
        end else begin
            case (e_state)
                E_IDLE: if (msg_acc) begin
                    if (bus.msg_type == 3'd7)
                        e_state <= E_DROP;
                    else if (RUN_STATUS != 0 && {1'b1, bus.msg_type, bus.msg_ch} == last_status)
                        e_state <= E_D1;
                    else
                        e_state <= E_STATUS;
                end
                E_STATUS: if (enc_load) begin
                    e_state     <= E_D1;
                    last_status <= status_byte;
                end
                E_D1: if (enc_load)
                    e_state <= (m_type == 3'd4 || m_type == 3'd5) ? E_IDLE : E_D2;
                E_D2: if (enc_load)
                    e_state <= E_IDLE;
                default: e_state <= E_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (msg_acc) begin
            m_type <= bus.msg_type;
            m_ch   <= bus.msg_ch;
            m_d1   <= bus.msg_d1;
            m_d2   <= bus.msg_d2;
        end
    end

    // Non-realtime values are accepted but never become pending.
    always_ff @(posedge CLOCK_25) begin
        if (reset)
            rt_pending <= 1'b0;
        else if (rt_acc)
            rt_pending <= (bus.rt_data >= 8'hF8);
        else if (rt_load)
            rt_pending <= 1'b0;
    end

    always_ff @(posedge CLOCK_25) begin
        if (rt_acc)
            rt_byte <= bus.rt_data;
    end

    always_comb begin
        line = 1'b1;
        case (s_state)
            S_START: line = 1'b0;
            S_DATA:  line = shift[0];
            default: line = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            s_state <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= 3'd0;
            txd_p0  <= 1'b1;
            sent_p0 <= 1'b0;
        end else begin
            txd_p0  <= line;
            sent_p0 <= (s_state == S_STOP) && bit_end;
            div_cnt <= (s_state == S_IDLE || bit_end) ? '0 : div_cnt + 1'b1;
            case (s_state)
                S_IDLE:  if (load) s_state <= S_START;
                S_START: if (bit_end) begin
                    s_state <= S_DATA;
                    bit_cnt <= 3'd0;
                end
                S_DATA:  if (bit_end) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) s_state <= S_STOP;
                end
                S_STOP:  if (bit_end) s_state <= load ? S_START : S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (load)
            shift <= load_byte;
        else if (s_state == S_DATA && bit_end)
            shift <= {1'b0, shift[7:1]};
    end

    assign bus.msg_ready = (e_state == E_IDLE);
    assign bus.rt_ready  = !rt_pending;
    assign bus.midi_txd  = txd_p0;
    assign bus.byte_sent = sent_p0;
    assign bus.tx_busy   = (e_state != E_IDLE) || (s_state != S_IDLE) || rt_pending;
endmodule

// File: tb/tb_midi_tx_encoder.sv
// Bench for midi_tx_encoder: two instances (running status on/off) share stimulus;
// line monitors decode 8N1 frames and compare against a byte-stream model.
module tb_midi_tx_encoder;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] mv = 2'b00, rtv = 2'b00;
    logic [2:0] mtype = 3'd0;
    logic [3:0] mch = 4'd0;
    logic [6:0] md1 = 7'd0, md2 = 7'd0;
    logic [7:0] rtd = 8'd0;
    logic [7:0] rv;
    logic [1:0] mrdy, rrdy, txd, busy, bs;

    midi_tx_encoder_if bus0 ();
    midi_tx_encoder_if bus1 ();

    assign bus0.msg_valid = mv[0];  assign bus1.msg_valid = mv[1];
    assign bus0.rt_valid  = rtv[0]; assign bus1.rt_valid  = rtv[1];
    assign bus0.msg_type = mtype; assign bus1.msg_type = mtype;
    assign bus0.msg_ch   = mch;   assign bus1.msg_ch   = mch;
    assign bus0.msg_d1   = md1;   assign bus1.msg_d1   = md1;
    assign bus0.msg_d2   = md2;   assign bus1.msg_d2   = md2;
    assign bus0.rt_data  = rtd;   assign bus1.rt_data  = rtd;
    assign mrdy = {bus1.msg_ready, bus0.msg_ready};
    assign rrdy = {bus1.rt_ready,  bus0.rt_ready};
    assign txd  = {bus1.midi_txd,  bus0.midi_txd};
    assign busy = {bus1.tx_busy,   bus0.tx_busy};
    assign bs   = {bus1.byte_sent, bus0.byte_sent};

    midi_tx_encoder #(.CLK_DIV(DIV), .RUN_STATUS(1)) dut0 (.CLOCK_25(clk), .reset(rst), .bus(bus0));
    midi_tx_encoder #(.CLK_DIV(DIV), .RUN_STATUS(0)) dut1 (.CLOCK_25(clk), .reset(rst), .bus(bus1));

    int n_chk = 0;
    int n_err = 0;
    int acc [2];
    logic [7:0] last_st [2];
    logic [7:0] em0[$], em1[$], er0[$], er1[$], lg0[$], lg1[$];
    int sc0[$], sc1[$];

    function automatic void chk(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push_em(input int d, input logic [7:0] b);
        if (d == 0) em0.push_back(b); else em1.push_back(b);
    endfunction

    function automatic void push_er(input int d, input logic [7:0] b);
        if (d == 0) er0.push_back(b); else er1.push_back(b);
    endfunction

    // Expected byte stream of one message under the running-status rules.
    function automatic void model_msg(input int d, input logic [2:0] t, input logic [3:0] ch,
                                      input logic [6:0] a, input logic [6:0] b);
        logic [7:0] st;
        if (t == 3'd7) return;
        st = {1'b1, t, ch};
        if (!(d == 0 && st == last_st[d])) push_em(d, st);
        last_st[d] = st;
        push_em(d, {1'b0, a});
        if (t != 3'd4 && t != 3'd5) push_em(d, {1'b0, b});
    endfunction

    function automatic void model_rt(input int d, input logic [7:0] v);
        if (v >= 8'hF8) push_er(d, v);
    endfunction

    function automatic void model_reset();
        em0.delete(); em1.delete(); er0.delete(); er1.delete();
        last_st[0] = 8'h00; last_st[1] = 8'h00;
    endfunction

    function automatic void clr_logs();
        lg0.delete(); lg1.delete(); sc0.delete(); sc1.delete();
    endfunction

    // Message and realtime bytes each keep their own order; compare per class.
    function automatic void expect_byte(input int d, input logic [7:0] got);
        logic [7:0] want;
        bit have;
        have = 1'b0;
        want = 8'h00;
        if (got >= 8'hF8) begin
            if (d == 0 && er0.size() > 0) begin want = er0.pop_front(); have = 1'b1; end
            if (d == 1 && er1.size() > 0) begin want = er1.pop_front(); have = 1'b1; end
        end else begin
            if (d == 0 && em0.size() > 0) begin want = em0.pop_front(); have = 1'b1; end
            if (d == 1 && em1.size() > 0) begin want = em1.pop_front(); have = 1'b1; end
        end
        chk(have && want == got, (d == 0) ? "rx_byte_rs1" : "rx_byte_rs0", got, want);
    endfunction

    task automatic monitor(input int d);
        logic [9:0] bits;
        int st;
        bit ab;
        forever begin
            @(negedge clk);
            if (!rst && txd[d] == 1'b0) begin
                st = cyc; ab = 1'b0; bits = '0;
                for (int o = 0; o < 10 * DIV; o++) begin
                    if (o > 0) @(negedge clk);
                    if (rst) begin ab = 1'b1; break; end
                    if (o % DIV == DIV / 2) bits[o / DIV] = txd[d];
                    chk(bs[d] == (o == 10 * DIV - 1), "byte_sent_frame", bs[d], (o == 10 * DIV - 1));
                end
                if (!ab) begin
                    chk(bits[0] == 1'b0, "start_bit", bits[0], 0);
                    chk(bits[9] == 1'b1, "stop_bit", bits[9], 1);
                    if (d == 0) begin lg0.push_back(bits[8:1]); sc0.push_back(st); end
                    else        begin lg1.push_back(bits[8:1]); sc1.push_back(st); end
                    expect_byte(d, bits[8:1]);
                end
            end else if (!rst) begin
                chk(bs[d] == 1'b0, "byte_sent_idle", bs[d], 0);
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic send_msg(input logic [2:0] t, input logic [3:0] ch,
                            input logic [6:0] a, input logic [6:0] b);
        logic [1:0] take;
        int w;
        @(negedge clk);
        mtype = t; mch = ch; md1 = a; md2 = b; mv = 2'b11; w = 0;
        while (mv != 2'b00) begin
            take = mv & mrdy;
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                if (take[d]) begin mv[d] = 1'b0; acc[d] = cyc; model_msg(d, t, ch, a, b); end
            if (mv != 2'b00) begin
                @(negedge clk); w++;
                if (w > 4000) begin chk(1'b0, "msg_accept_timeout", int'(mv), 0); mv = 2'b00; end
            end
        end
    endtask

    task automatic send_rt(input logic [7:0] v);
        logic [1:0] take;
        int w;
        @(negedge clk);
        rtd = v; rtv = 2'b11; w = 0;
        while (rtv != 2'b00) begin
            take = rtv & rrdy;
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++)
                if (take[d]) begin rtv[d] = 1'b0; model_rt(d, v); end
            if (rtv != 2'b00) begin
                @(negedge clk); w++;
                if (w > 4000) begin chk(1'b0, "rt_accept_timeout", int'(rtv), 0); rtv = 2'b00; end
            end
        end
    endtask

    task automatic wait_idle();
        int quiet, w;
        quiet = 0; w = 0;
        while (quiet < 16 && w < 20000) begin
            @(negedge clk); w++;
            if (busy == 2'b00 && txd == 2'b11) quiet++; else quiet = 0;
        end
        chk(quiet >= 16, "idle_timeout", w, 20000);
        chk(em0.size() + em1.size() == 0, "msg_bytes_missing", em0.size() + em1.size(), 0);
        chk(er0.size() + er1.size() == 0, "rt_bytes_missing", er0.size() + er1.size(), 0);
    endtask

    // Literal byte list, first byte in e[63:56].
    function automatic void check_log(input int d, input int n, input logic [63:0] e, input string name);
        int sz;
        logic [7:0] g, w;
        sz = (d == 0) ? lg0.size() : lg1.size();
        chk(sz == n, name, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            g = (d == 0) ? lg0[i] : lg1[i];
            w = e[63 - 8 * i -: 8];
            chk(g == w, name, g, w);
        end
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk(txd == 2'b11, "reset_txd", txd, 3);
        chk(mrdy == 2'b11, "reset_msg_ready", mrdy, 3);
        chk(rrdy == 2'b11, "reset_rt_ready", rrdy, 3);
        chk(busy == 2'b00, "reset_tx_busy", busy, 0);
        chk(bs == 2'b00, "reset_byte_sent", bs, 0);

        clr_logs();
        send_msg(3'd1, 4'd0, 7'h3C, 7'h64);
        wait_idle();
        check_log(0, 3, 64'h90_3C_64_00_00_00_00_00, "noteon_rs1");
        check_log(1, 3, 64'h90_3C_64_00_00_00_00_00, "noteon_rs0");
        if (sc0.size() == 3) begin
            chk(sc0[0] - acc[0] == 2, "msg_latency", sc0[0] - acc[0], 2);
            chk(sc0[1] - sc0[0] == 10 * DIV, "gap_1", sc0[1] - sc0[0], 10 * DIV);
            chk(sc0[2] + 10 * DIV - sc0[0] == 240, "span_3_bytes", sc0[2] + 10 * DIV - sc0[0], 240);
        end

        clr_logs();
        send_msg(3'd1, 4'd0, 7'h3E, 7'h00);
        wait_idle();
        check_log(0, 2, 64'h3E_00_00_00_00_00_00_00, "run_status_rs1");
        check_log(1, 3, 64'h90_3E_00_00_00_00_00_00, "run_status_rs0");

        clr_logs();
        send_msg(3'd3, 4'd2, 7'h07, 7'h7F);
        send_msg(3'd4, 4'd5, 7'h0A, 7'h55);
        send_msg(3'd6, 4'd0, 7'h00, 7'h40);
        wait_idle();
        check_log(0, 8, 64'hB2_07_7F_C5_0A_E0_00_40, "cc_pc_pb_rs1");
        check_log(1, 8, 64'hB2_07_7F_C5_0A_E0_00_40, "cc_pc_pb_rs0");

        clr_logs();
        send_msg(3'd1, 4'd0, 7'h3C, 7'h64);
        repeat (2 + 10 * DIV + 20) @(posedge clk);
        send_rt(8'hF8);
        wait_idle();
        send_msg(3'd1, 4'd0, 7'h3E, 7'h00);
        wait_idle();
        check_log(0, 6, 64'h90_3C_F8_64_3E_00_00_00, "rt_insert_rs1");
        check_log(1, 7, 64'h90_3C_F8_64_90_3E_00_00, "rt_insert_rs0");

        clr_logs();
        send_rt(8'h80);
        chk(rrdy == 2'b11, "rt_discard_ready", rrdy, 3);
        repeat (20) @(posedge clk);
        chk(lg0.size() + lg1.size() == 0, "rt_discard_silent", lg0.size() + lg1.size(), 0);

        send_msg(3'd7, 4'd0, 7'h11, 7'h22);
        chk(mrdy == 2'b00, "drop_ready_low", mrdy, 0);
        @(posedge clk); #1;
        chk(mrdy == 2'b11, "drop_ready_back", mrdy, 3);
        begin
            int lows;
            lows = 0;
            repeat (20) begin @(negedge clk); if (txd != 2'b11) lows++; end
            chk(lows == 0, "drop_line_idle", lows, 0);
        end
        send_msg(3'd1, 4'd0, 7'h01, 7'h02);
        wait_idle();
        check_log(0, 2, 64'h01_02_00_00_00_00_00_00, "drop_keeps_status_rs1");
        check_log(1, 3, 64'h90_01_02_00_00_00_00_00, "drop_keeps_status_rs0");

        clr_logs();
        begin
            logic [1:0] mt, rt;
            @(negedge clk);
            mtype = 3'd1; mch = 4'd1; md1 = 7'h10; md2 = 7'h20; rtd = 8'hFA;
            mv = 2'b11; rtv = 2'b11;
            mt = mv & mrdy; rt = rtv & rrdy;
            @(posedge clk); #1;
            chk(mt == 2'b11 && rt == 2'b11, "simul_accept", {mt, rt}, 15);
            for (int d = 0; d < 2; d++) begin
                acc[d] = cyc; model_rt(d, 8'hFA); model_msg(d, 3'd1, 4'd1, 7'h10, 7'h20);
            end
            mv = 2'b00; rtv = 2'b00;
        end
        wait_idle();
        check_log(0, 4, 64'hFA_91_10_20_00_00_00_00, "simul_rt_first");
        if (sc0.size() > 0) chk(sc0[0] - acc[0] == 2, "rt_latency", sc0[0] - acc[0], 2);

        clr_logs();
        send_msg(3'd1, 4'd0, 7'h3C, 7'h64);
        repeat (2 + 2 * DIV + 3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk(txd == 2'b11, "abort_txd", txd, 3);
        chk(busy == 2'b00, "abort_tx_busy", busy, 0);
        chk(mrdy == 2'b11, "abort_msg_ready", mrdy, 3);
        chk(rrdy == 2'b11, "abort_rt_ready", rrdy, 3);
        model_reset();
        clr_logs();
        send_msg(3'd1, 4'd0, 7'h3C, 7'h64);
        wait_idle();
        check_log(0, 3, 64'h90_3C_64_00_00_00_00_00, "after_reset_rs1");
        check_log(1, 3, 64'h90_3C_64_00_00_00_00_00, "after_reset_rs0");

        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 60)) @(posedge clk);
                    send_msg(3'($urandom_range(0, 7)), 4'($urandom_range(0, 2)),
                             7'($urandom), 7'($urandom));
                end
            end
            begin
                for (int k = 0; k < 15; k++) begin
                    repeat ($urandom_range(0, 400)) @(posedge clk);
                    rv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(248, 255))
                                                     : 8'($urandom_range(0, 247));
                    send_rt(rv);
                end
            end
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
